song_recorder: RTL and testbench
================================

# song_recorder

Captures live free-mode playing (note plus octave from the key controller) into an on-chip song buffer of (note, octave, duration) entries while `write_on` is held. It is the writer side of the song memory that the auto/learn playback path reads. It sits between the controller's note/octave outputs and the playback sequencer's read port. Durations are quantised to a fixed tick, and sub-tick glitches are discarded.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_MS`, 50, duration quantum in ms; `TICK_CYCLES = CLK_HZ/1000*TICK_MS`.
- `DEPTH`, 32, number of buffer entries (power of two).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `write_on`  in  1  record enable (level); a rising edge starts a take, a falling edge ends it.
- `note_in`  in  4  current note: 0 = rest, 1–7 = do..si; 8–15 are treated as rest.
- `octave_in`  in  2  current octave.
- `rd_addr`  in  log2(DEPTH)  playback read address.
- `rd_note`  out  4  note at `rd_addr`, registered.
- `rd_octave`  out  2  octave at `rd_addr`, registered.
- `rd_dur`  out  8  duration in ticks at `rd_addr`, registered.
- `length`  out  log2(DEPTH)+1  number of committed entries.
- `recording`  out  1  high in state REC.
- `full`  out  1  high when `length == DEPTH`.

## Operation
- The states are IDLE, REC and FULL. Reset state is IDLE.
- `write_on` is registered once for edge detection.
- **IDLE → REC** on a `write_on` rising edge:
  - `length` := 0.
  - Open event := (`note_in`, `octave_in`), `dur` := 0.
  - The tick counter is cleared.
- **In REC**, per clock:
  - The tick counter counts 0..TICK_CYCLES-1. On wrap, `dur` increments.
  - Key change: if (`note_in`, `octave_in`) differs from the open event, commit the open event if `dur ≥ 1`, else drop it. Then open a new event with `dur` := 0 and clear the tick counter.
  - Saturation: if `dur` reaches 255, commit it and reopen the same note with `dur` := 0. A long note therefore becomes consecutive same-note entries.
  - `write_on` falling edge: commit the open event if `dur ≥ 1`, then go to IDLE.
  - A commit that makes `length == DEPTH` moves to FULL. Any further change or saturation in that cycle is ignored.
- **FULL**: no writes. A `write_on` falling edge returns to IDLE. `length` holds.
- Commit: `mem[length] <= {note, octave, dur}`, then `length` increments. At most one commit per cycle.
- Simultaneous key change and `write_on` fall in the same cycle: commit the old event only, then go to IDLE.
- Simultaneous key change and tick wrap: the wrap is credited to the old event before the commit decision.
- Reset mid-take: `length` := 0 and state := IDLE. Memory contents are unspecified, but reads never beyond `length` are required.
- A new take always overwrites from entry 0.
- The read port is independent of state. Reads during REC return stale or new data without hazard guarantees.

## Timing
- Reset values: `rd_note`, `rd_octave` and `rd_dur` = 0; `length` = 0; `recording` = 0; `full` = 0.
- Read latency is 1 clock from `rd_addr` to `rd_*`.
- `recording` rises 2 clocks after `write_on` rises on the pin (edge-detect register plus state register).
- A commit is visible in `length` the clock after the triggering condition is sampled. Data at that index is readable from the following cycle.
- Stored duration = floor(held cycles / TICK_CYCLES), saturating per entry at 255.
- Inputs are synchronous to `clk`. Synchronisation and debouncing of the keys happen upstream.

## Configuration
- `SONG_REC_TRIM_EN`:
  - Defined: rest events (`note` 0) are never committed while `length == 0`, so a take starts on the first sounded note. Trailing rests are still recorded.
  - Undefined: leading rests are committed like any other event.

## Test plan
Bench parameters are CLK_HZ=1000 and TICK_MS=10, giving TICK_CYCLES=10.
- Take of note 3/oct 1 held 35 cycles, then `write_on` falls → `length`=1, entry0={3,1,3}.
- Note 5 for 25 cycles, then note 5 held 4 cycles, then note 2 held 20 cycles → the 4-cycle glitch is dropped; entries {5,·,2},{2,·,2}, `length`=2.
- Note 1 held 2600 cycles → entries {1,·,255},{1,·,5}.
- 33 notes of 10 cycles each with DEPTH=32 → `full`=1 after the 32nd commit, `recording`=0, 33rd not stored, `length`=32. `write_on` low → IDLE.
- Assert `reset` during REC with `length`=4 → all outputs return to reset values immediately. A new take starts at entry 0.
- Take starting with a 30-cycle rest, then note 4 for 10 cycles → with `SONG_REC_TRIM_EN`, entry0={4,·,1}, `length`=1. Without it, entry0={0,·,3} and `length`=2.

Source files
------------

// File: rtl/song_recorder.sv
// Live-take recorder: quantises (note, octave) hold times into a DEPTH-entry song buffer.
// Optional feature macro: SONG_REC_TRIM_EN (drop leading rests of a take).
module song_recorder #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_MS = 50,
  parameter int DEPTH   = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_on,
  input  logic [3:0]    note_in,
  input  logic [1:0]    octave_in,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_note,
  output logic [1:0]    rd_octave,
  output logic [7:0]    rd_dur,
  output logic [AW:0]   length,
  output logic          recording,
  output logic          full
);
  localparam int TICK_CYCLES = CLK_HZ / 1000 * TICK_MS;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REC, FULL} state_t;
  state_t state, state_n;

  logic          wr_q, wr_qq;
  logic [3:0]    note_q, cur_note;
  logic [1:0]    oct_q, cur_oct;
  logic [7:0]    dur, dur_eff;
  logic [TW-1:0] tick;
  logic [13:0]   mem [DEPTH];

  logic rise, fall, wrap, changed, keep;
  logic commit, open_ev, reopen, clr_len;

  assign rise    = wr_q & ~wr_qq;
  assign fall    = ~wr_q & wr_qq;
  assign wrap    = (tick == TW'(TICK_CYCLES - 1));
  // a wrap in the same cycle as a key change still belongs to the old event
  assign dur_eff = dur + 8'(wrap);
  assign changed = {note_q, oct_q} != {cur_note, cur_oct};
`ifdef SONG_REC_TRIM_EN
  assign keep    = (dur_eff != 8'd0) && !((cur_note == 4'd0) && (length == '0));
`else
  assign keep    = (dur_eff != 8'd0);
`endif

  assign recording = (state == REC);
  assign full      = (length == (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    open_ev = 1'b0;
    reopen  = 1'b0;
    clr_len = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = REC;
        open_ev = 1'b1;
        clr_len = 1'b1;
      end
      REC: begin
        if (fall) begin
          commit  = keep;
          state_n = IDLE;
        end else if (changed) begin
          commit  = keep;
          open_ev = 1'b1;
        end else if (dur_eff == 8'hFF) begin
          commit  = keep;
          reopen  = 1'b1;
        end
        if (commit && !fall && (length == (AW+1)'(DEPTH - 1))) state_n = FULL;
      end
      FULL: if (fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // inputs are registered once so edge detect and key compare share one timebase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      wr_qq    <= 1'b0;
      note_q   <= '0;
      oct_q    <= '0;
      cur_note <= '0;
      cur_oct  <= '0;
      dur      <= '0;
      tick     <= '0;
      length   <= '0;
    end else begin
      wr_q   <= write_on;
      wr_qq  <= wr_q;
      note_q <= (note_in > 4'd7) ? 4'd0 : note_in;
      oct_q  <= octave_in;
      if (state == REC) begin
        tick <= wrap ? '0 : tick + TW'(1);
        dur  <= dur_eff;
      end
      if (reopen) dur <= '0;
      if (open_ev) begin
        cur_note <= note_q;
        cur_oct  <= oct_q;
        dur      <= '0;
        tick     <= '0;
      end
      if (clr_len)     length <= '0;
      else if (commit) length <= length + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[length[AW-1:0]] <= {cur_note, cur_oct, dur_eff};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_note   <= '0;
      rd_octave <= '0;
      rd_dur    <= '0;
    end else begin
      {rd_note, rd_octave, rd_dur} <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with TICK_CYCLES = 10.
module tb_song_recorder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_on = 1'b0;
  logic [3:0] note_in = '0;
  logic [1:0] octave_in = '0;
  logic [4:0] rd_addr = '0;
  logic [3:0] rd_note;
  logic [1:0] rd_octave;
  logic [7:0] rd_dur;
  logic [5:0] length;
  logic       recording, full;

  int ntests = 0;
  int nfail  = 0;

  song_recorder #(.CLK_HZ(1000), .TICK_MS(10), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .write_on(write_on), .note_in(note_in),
    .octave_in(octave_in), .rd_addr(rd_addr), .rd_note(rd_note),
    .rd_octave(rd_octave), .rd_dur(rd_dur), .length(length),
    .recording(recording), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_entry(input int a, output logic [13:0] e);
    rd_addr = 5'(a);
    step(1);
    e = {rd_note, rd_octave, rd_dur};
  endtask

  task automatic test_reset;
    step(2);
    ntests++;
    if ({rd_note, rd_octave, rd_dur, length, recording, full} !== 22'd0) begin
      nfail++;
      $display("FAIL reset_state got %h exp 0", {rd_note, rd_octave, rd_dur, length, recording, full});
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_single;
    logic [13:0] e;
    write_on = 1'b1; note_in = 4'd3; octave_in = 2'd1;
    step(1);
    ntests++;
    if (recording !== 1'b0) begin nfail++; $display("FAIL rec_early got %b exp 0", recording); end
    step(1);
    ntests++;
    if (recording !== 1'b1) begin nfail++; $display("FAIL rec_rise got %b exp 1", recording); end
    step(33);
    write_on = 1'b0; note_in = 4'd0;
    step(2);
    ntests++;
    if (length !== 6'd1) begin nfail++; $display("FAIL single_len got %0d exp 1", length); end
    ntests++;
    if (recording !== 1'b0) begin nfail++; $display("FAIL single_idle got %b exp 0", recording); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd3, 2'd1, 8'd3}) begin nfail++; $display("FAIL single_e0 got %h exp %h", e, {4'd3, 2'd1, 8'd3}); end
    step(3);
  endtask

  task automatic test_glitch;
    logic [13:0] e;
    write_on = 1'b1; note_in = 4'd5; octave_in = 2'd1;
    step(25);
    octave_in = 2'd2;
    step(4);
    note_in = 4'd2; octave_in = 2'd1;
    step(20);
    write_on = 1'b0; note_in = 4'd0;
    step(2);
    ntests++;
    if (length !== 6'd2) begin nfail++; $display("FAIL glitch_len got %0d exp 2", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd5, 2'd1, 8'd2}) begin nfail++; $display("FAIL glitch_e0 got %h exp %h", e, {4'd5, 2'd1, 8'd2}); end
    read_entry(1, e);
    ntests++;
    if (e !== {4'd2, 2'd1, 8'd2}) begin nfail++; $display("FAIL glitch_e1 got %h exp %h", e, {4'd2, 2'd1, 8'd2}); end
    step(3);
  endtask

  task automatic test_saturate;
    logic [13:0] e;
    write_on = 1'b1; note_in = 4'd1; octave_in = 2'd2;
    step(2600);
    write_on = 1'b0; note_in = 4'd0;
    step(2);
    ntests++;
    if (length !== 6'd2) begin nfail++; $display("FAIL sat_len got %0d exp 2", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd1, 2'd2, 8'd255}) begin nfail++; $display("FAIL sat_e0 got %h exp %h", e, {4'd1, 2'd2, 8'd255}); end
    read_entry(1, e);
    ntests++;
    if (e !== {4'd1, 2'd2, 8'd5}) begin nfail++; $display("FAIL sat_e1 got %h exp %h", e, {4'd1, 2'd2, 8'd5}); end
    step(3);
  endtask

  task automatic test_full;
    logic [13:0] e;
    write_on = 1'b1; octave_in = 2'd0;
    for (int k = 0; k < 33; k++) begin
      note_in = (k % 2 == 1) ? 4'd2 : 4'd1;
      step(10);
    end
    ntests++;
    if ({full, recording, length} !== {1'b1, 1'b0, 6'd32}) begin
      nfail++;
      $display("FAIL full_state got full=%b rec=%b len=%0d exp full=1 rec=0 len=32", full, recording, length);
    end
    write_on = 1'b0; note_in = 4'd0;
    step(3);
    ntests++;
    if (length !== 6'd32) begin nfail++; $display("FAIL full_hold got %0d exp 32", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd1, 2'd0, 8'd1}) begin nfail++; $display("FAIL full_e0 got %h exp %h", e, {4'd1, 2'd0, 8'd1}); end
    read_entry(31, e);
    ntests++;
    if (e !== {4'd2, 2'd0, 8'd1}) begin nfail++; $display("FAIL full_e31 got %h exp %h", e, {4'd2, 2'd0, 8'd1}); end
    step(3);
  endtask

  task automatic test_reset_mid;
    logic [13:0] e;
    write_on = 1'b1; octave_in = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      note_in = 4'(k);
      step(10);
    end
    ntests++;
    if ({full, recording, length} !== {1'b0, 1'b1, 6'd4}) begin
      nfail++;
      $display("FAIL mid_pre got full=%b rec=%b len=%0d exp full=0 rec=1 len=4", full, recording, length);
    end
    read_entry(3, e);
    ntests++;
    if (e !== {4'd4, 2'd0, 8'd1}) begin nfail++; $display("FAIL mid_e3 got %h exp %h", e, {4'd4, 2'd0, 8'd1}); end
    #2 reset = 1'b1; write_on = 1'b0;
    #1;
    ntests++;
    if ({rd_note, rd_octave, rd_dur, length, recording, full} !== 22'd0) begin
      nfail++;
      $display("FAIL mid_reset got %h exp 0", {rd_note, rd_octave, rd_dur, length, recording, full});
    end
    #1 reset = 1'b0;
    step(2);
    write_on = 1'b1; note_in = 4'd6; octave_in = 2'd2;
    step(20);
    write_on = 1'b0; note_in = 4'd0;
    step(2);
    ntests++;
    if (length !== 6'd1) begin nfail++; $display("FAIL retake_len got %0d exp 1", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd6, 2'd2, 8'd2}) begin nfail++; $display("FAIL retake_e0 got %h exp %h", e, {4'd6, 2'd2, 8'd2}); end
    step(3);
  endtask

  // the leading rest is driven as note 9, which must be recorded as rest
  task automatic test_trim;
    logic [13:0] e;
    write_on = 1'b1; note_in = 4'd9; octave_in = 2'd0;
    step(30);
    note_in = 4'd4; octave_in = 2'd1;
    step(10);
    write_on = 1'b0; note_in = 4'd0; octave_in = 2'd0;
    step(2);
`ifdef SONG_REC_TRIM_EN
    ntests++;
    if (length !== 6'd1) begin nfail++; $display("FAIL trim_len got %0d exp 1", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd4, 2'd1, 8'd1}) begin nfail++; $display("FAIL trim_e0 got %h exp %h", e, {4'd4, 2'd1, 8'd1}); end
`else
    ntests++;
    if (length !== 6'd2) begin nfail++; $display("FAIL rest_len got %0d exp 2", length); end
    read_entry(0, e);
    ntests++;
    if (e !== {4'd0, 2'd0, 8'd3}) begin nfail++; $display("FAIL rest_e0 got %h exp %h", e, {4'd0, 2'd0, 8'd3}); end
    read_entry(1, e);
    ntests++;
    if (e !== {4'd4, 2'd1, 8'd1}) begin nfail++; $display("FAIL rest_e1 got %h exp %h", e, {4'd4, 2'd1, 8'd1}); end
`endif
    step(3);
  endtask

  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_saturate;
    test_full;
    test_reset_mid;
    test_trim;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
